// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO read-side transmit feeder.
// State encoding and counter-width helpers used across the feeder files.
package fifo_pkg;

    localparam int ST_W = 3;

    typedef enum logic [ST_W-1:0] {
        IDLE      = 3'd0,
        SEND      = 3'd1,
        WAIT_ACK  = 3'd2,
        WAIT_DONE = 3'd3,
        GAP       = 3'd4
    } state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Counters need at least one bit even for degenerate limits.
    function automatic int cnt_w(input int v);
        return (clog2(v) < 1) ? 1 : clog2(v);
    endfunction

endpackage

// File: rtl/feeder_cnt.sv
// Clearable up-counter with a terminal-count flag at value TC.
// Clear has priority over enable.
module feeder_cnt #(
    parameter int W  = 4,
    parameter int TC = 15
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == W'(TC));

endmodule

// File: rtl/fifo_tx_feeder.sv
// Pops async-FIFO words into a busy-handshake serial transmitter.
// Define FEEDER_GAP_EN to add GAP_CYCLES idle cycles between words.
module fifo_tx_feeder
    import fifo_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int TO_CYCLES  = 16,
    parameter int GAP_CYCLES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             rempty,
    input  logic [WIDTH-1:0] rdata,
    output logic             rinc,
    input  logic             tx_busy,
    output logic [WIDTH-1:0] tx_data,
    output logic             tx_valid,
    output logic             timeout_err
);

    localparam int TO_W = cnt_w(TO_CYCLES);

    state_e           state_q;
    state_e           state_d;
    state_e           done_next;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             err_q;
    logic             err_d;
    logic             pop;
    logic             to_clr;
    logic             to_en;
    logic             to_tc;

    // Reset gating keeps the pop strobe quiet while RST is held.
    assign pop = RST && (state_q == IDLE) && !rempty && !tx_busy;

    feeder_cnt #(
        .W  (TO_W),
        .TC (TO_CYCLES - 1)
    ) u_to_cnt (
        .clk_i  (CLK),
        .rst_ni (RST),
        .clr_i  (to_clr),
        .en_i   (to_en),
        .tc_o   (to_tc)
    );

`ifdef FEEDER_GAP_EN
    localparam int GAP_W  = cnt_w(GAP_CYCLES);
    localparam int GAP_TC = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    logic gap_clr;
    logic gap_en;
    logic gap_tc;

    feeder_cnt #(
        .W  (GAP_W),
        .TC (GAP_TC)
    ) u_gap_cnt (
        .clk_i  (CLK),
        .rst_ni (RST),
        .clr_i  (gap_clr),
        .en_i   (gap_en),
        .tc_o   (gap_tc)
    );

    assign done_next = (GAP_CYCLES == 0) ? IDLE : GAP;
    assign gap_clr   = (state_q == WAIT_DONE);
    assign gap_en    = (state_q == GAP);
`else
    logic unused_gap;

    assign unused_gap = ^GAP_CYCLES;
    assign done_next  = IDLE;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (pop) state_d = SEND;
            end
            SEND: begin
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (to_tc) begin
                    state_d = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) state_d = done_next;
            end
`ifdef FEEDER_GAP_EN
            GAP: begin
                if (gap_tc) state_d = IDLE;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        rinc     = pop;
        tx_valid = (state_q == SEND);
        data_d   = pop ? rdata : data_q;
        to_clr   = (state_q == SEND);
        to_en    = (state_q == WAIT_ACK) && !tx_busy && !to_tc;
        err_d    = err_q
                 | ((state_q == WAIT_ACK) && !tx_busy && to_tc);
    end

    assign tx_data     = data_q;
    assign timeout_err = err_q;

endmodule
